// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Frame scheduler around an N-point streaming FFT core. Upstream samples are
// packed into fixed N-slot frames on the core input. The core output is tagged
// with valid, natural bin index and first/last markers, so downstream logic
// never has to track the core pipeline latency.
//
// Ports:
//   clk, rstx      clock, synchronous active-low reset
//   abort          drop everything in flight and return to CLEAR
//   s_valid/s_ready/s_data   upstream sample stream (no slips inside a frame)
//   fft_clear, fft_din       registered core controls / input
//   fft_dout                 core output {im, re}
//   m_valid, m_data, m_bin, m_first, m_last   tagged spectrum output
//   underrun       sticky: a live frame was missing a sample
//   frame_cnt      frames emitted, wraps
module fft_frame_ctrl #(
    parameter int N       = 8,
    parameter int LOGN    = 3,
    parameter int DW      = 8,
    parameter int LATENCY = 8,
    parameter int BITREV  = 1
) (
    input  logic            clk,
    input  logic            rstx,
    input  logic            abort,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    output logic            fft_clear,
    output logic [DW-1:0]   fft_din,
    input  logic [2*DW-1:0] fft_dout,
    output logic            m_valid,
    output logic [2*DW-1:0] m_data,
    output logic [LOGN-1:0] m_bin,
    output logic            m_first,
    output logic            m_last,
    output logic            underrun,
    output logic [15:0]     frame_cnt
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state, state_nx;
    logic [LOGN-1:0] pos, pos_nx;
    logic            live, live_nx;
    logic [DW-1:0]   din_nx;
    logic            tag_live, tag_first;
    logic            tag_live_nx, tag_first_nx;
    logic            stall;
    // Tag delay line: lines up {live, first} with the core's output.
    logic [LATENCY-1:0] sr_live, sr_first;
    logic [LOGN-1:0]    slot, slot_nx;

    function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstx) state <= CLEAR;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        pos_nx       = pos;
        live_nx      = live;
        din_nx       = '0;
        tag_live_nx  = 1'b0;
        tag_first_nx = 1'b0;
        stall        = 1'b0;
        s_ready      = 1'b0;
        unique case (state)
            CLEAR: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_nx     = RUN;
                    pos_nx       = LOGN'(1);
                    live_nx      = 1'b1;
                    din_nx       = s_data;
                    tag_live_nx  = 1'b1;
                    tag_first_nx = 1'b1;
                end
            end
            RUN: begin
                pos_nx = pos + 1'b1;
                if (pos == '0) begin
                    // Frame liveness is decided once, at slot 0.
                    s_ready      = 1'b1;
                    live_nx      = s_valid;
                    din_nx       = s_valid ? s_data : '0;
                    tag_live_nx  = s_valid;
                    tag_first_nx = 1'b1;
                end else if (live) begin
                    // Stalls inside a live frame become zero samples, never slips.
                    s_ready     = 1'b1;
                    din_nx      = s_valid ? s_data : '0;
                    stall       = ~s_valid;
                    tag_live_nx = 1'b1;
                end
            end
            default: state_nx = CLEAR;
        endcase
        if (abort) state_nx = CLEAR;
        if (!rstx) s_ready = 1'b0;
    end

    // Output slot counter restarts on every frame marker leaving the delay line.
    always_comb begin
        slot_nx = sr_first[LATENCY-1] ? '0 : slot + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstx) begin
            pos       <= '0;
            live      <= 1'b0;
            fft_clear <= 1'b1;
            fft_din   <= '0;
            tag_live  <= 1'b0;
            tag_first <= 1'b0;
            sr_live   <= '0;
            sr_first  <= '0;
            slot      <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_bin     <= '0;
            m_first   <= 1'b0;
            m_last    <= 1'b0;
            underrun  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            m_data <= fft_dout;
            if (abort) begin
                pos       <= '0;
                live      <= 1'b0;
                fft_clear <= 1'b1;
                fft_din   <= '0;
                tag_live  <= 1'b0;
                tag_first <= 1'b0;
                sr_live   <= '0;
                sr_first  <= '0;
                slot      <= '0;
                m_valid   <= 1'b0;
                m_bin     <= '0;
                m_first   <= 1'b0;
                m_last    <= 1'b0;
                underrun  <= 1'b0;
            end else begin
                pos       <= pos_nx;
                live      <= live_nx;
                fft_clear <= (state_nx == CLEAR);
                fft_din   <= din_nx;
                tag_live  <= tag_live_nx;
                tag_first <= tag_first_nx;
                sr_live[0]  <= tag_live;
                sr_first[0] <= tag_first;
                for (int i = 1; i < LATENCY; i++) begin
                    sr_live[i]  <= sr_live[i-1];
                    sr_first[i] <= sr_first[i-1];
                end
                slot    <= slot_nx;
                m_bin   <= (BITREV != 0) ? bit_rev(slot_nx) : slot_nx;
                m_valid <= sr_live[LATENCY-1];
                m_first <= sr_live[LATENCY-1] & sr_first[LATENCY-1];
                m_last  <= sr_live[LATENCY-1] & (slot_nx == LOGN'(N-1));
                if (stall)  underrun  <= 1'b1;
                if (m_last) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
